// File: rtl/mssd_pkg.sv
// ---------------------------------------------------------------------------
// mssd_pkg : shared types and field widths for the serial frame demux
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mssd_pkg;

  localparam int PORT_W    = 2;
  localparam int LEN_W     = 4;
  localparam int NUM_PORTS = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PORT = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    ERR  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mssd_ctrl.sv
// ---------------------------------------------------------------------------
// mssd_ctrl : frame FSM and header bit counter
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mssd_ctrl
  import mssd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ser_i,
  input  logic   len_zero_i,
  input  logic   cnt_last_i,
  output state_e state_o,
  output logic   port_last_o,
  output logic   len_last_o
);

  state_e     state_q, state_d;
  logic [1:0] hdr_q, hdr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hdr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    port_last_o = 1'b0;
    len_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ser_i) begin
          state_d = PORT;
          hdr_d   = 2'd0;
        end
      end
      PORT: begin
        if (hdr_q == 2'(PORT_W - 1)) begin
          port_last_o = 1'b1;
          state_d     = LEN;
          hdr_d       = 2'd0;
        end else begin
          hdr_d = hdr_q + 2'd1;
        end
      end
      LEN: begin
        // Zero test uses the length including the bit sampled this cycle.
        if (hdr_q == 2'(LEN_W - 1)) begin
          len_last_o = 1'b1;
          state_d    = len_zero_i ? ERR : DATA;
          hdr_d      = 2'd0;
        end else begin
          hdr_d = hdr_q + 2'd1;
        end
      end
      DATA: begin
        if (cnt_last_i) state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/mssd_dp.sv
// ---------------------------------------------------------------------------
// mssd_dp : header shift registers, payload down-counter and 1-to-4 demux
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mssd_dp
  import mssd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_i,
  input  state_e               state_i,
  input  logic                 port_last_i,
  input  logic                 len_last_i,
  output logic                 len_zero_o,
  output logic                 cnt_last_o,
  output logic [PORT_W-1:0]    port_o,
  output logic                 valid_o,
  output logic                 error_o,
  output logic [NUM_PORTS-1:0] out_o
);

  logic [PORT_W-2:0] port_sh_q, port_sh_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic [LEN_W-2:0]  len_sh_q, len_sh_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [PORT_W-1:0] w_port_full;
  logic [LEN_W-1:0]  w_len_full;

  assign w_port_full = {port_sh_q, ser_i};
  assign w_len_full  = {len_sh_q, ser_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_sh_q <= '0;
      port_q    <= '0;
      len_sh_q  <= '0;
      count_q   <= '0;
    end else begin
      port_sh_q <= port_sh_d;
      port_q    <= port_d;
      len_sh_q  <= len_sh_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    port_sh_d = port_sh_q;
    port_d    = port_q;
    len_sh_d  = len_sh_q;
    count_d   = count_q;
    if (state_i == PORT) port_sh_d = w_port_full[PORT_W-2:0];
    // Active port only changes once the whole field has arrived.
    if (port_last_i)     port_d    = w_port_full;
    if (state_i == LEN)  len_sh_d  = w_len_full[LEN_W-2:0];
    if (len_last_i) begin
      count_d = w_len_full;
    end else if (state_i == DATA && count_q != '0) begin
      count_d = count_q - LEN_W'(1);
    end
  end

  assign len_zero_o = (w_len_full == '0);
  assign cnt_last_o = (count_q == LEN_W'(1));
  assign port_o     = port_q;
  assign valid_o    = (state_i == DATA);
  assign error_o    = (state_i == ERR);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_demux
      assign out_o[gi] = valid_o && (port_q == PORT_W'(gi)) && ser_i;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mssd.sv
// ---------------------------------------------------------------------------
// mssd : serial frame demultiplexer, routes payload bits to one of four lines
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mssd
  import mssd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serIn,
  output logic                 error,
  output logic                 validOut,
  output logic [PORT_W-1:0]    activePort,
  output logic [NUM_PORTS-1:0] out
);

  state_e w_state;
  logic   w_port_last;
  logic   w_len_last;
  logic   w_len_zero;
  logic   w_cnt_last;

  mssd_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .ser_i       (serIn),
    .len_zero_i  (w_len_zero),
    .cnt_last_i  (w_cnt_last),
    .state_o     (w_state),
    .port_last_o (w_port_last),
    .len_last_o  (w_len_last)
  );

  mssd_dp u_dp (
    .clk         (clk),
    .rst         (rst),
    .ser_i       (serIn),
    .state_i     (w_state),
    .port_last_i (w_port_last),
    .len_last_i  (w_len_last),
    .len_zero_o  (w_len_zero),
    .cnt_last_o  (w_cnt_last),
    .port_o      (activePort),
    .valid_o     (validOut),
    .error_o     (error),
    .out_o       (out)
  );

endmodule

`default_nettype wire

// File: tb/tb_mssd.sv
// ---------------------------------------------------------------------------
// tb_mssd : directed self-checking bench for the serial frame demultiplexer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mssd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serIn = 1'b1;
  logic       error;
  logic       validOut;
  logic [1:0] activePort;
  logic [3:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  mssd dut (
    .clk        (clk),
    .rst        (rst),
    .serIn      (serIn),
    .error      (error),
    .validOut   (validOut),
    .activePort (activePort),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Called at posedge+1: drive one serial bit, check mid-cycle, advance.
  // exp = {error, validOut, out[3:0]}
  task automatic cyc(input logic b, input logic [5:0] exp, input logic [1:0] ep,
                     input bit chk_p, input string tag);
    serIn = b;
    #5;
    check(tag, {2'b00, error, validOut, out}, {2'b00, exp});
    if (chk_p) check({tag, "_port"}, {6'b0, activePort}, {6'b0, ep});
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [1:0] p, input logic [3:0] n, input logic [14:0] pay,
                       input int lim, input string tag);
    logic [3:0] onehot;
    onehot = 4'b0001 << p;
    cyc(1'b0, 6'b000000, 2'd0, 1'b0, {tag, "_start"});
    for (int i = 0; i < 2; i++) cyc(p[1-i], 6'b000000, 2'd0, 1'b0, {tag, "_porthdr"});
    for (int i = 0; i < 4; i++) cyc(n[3-i], 6'b000000, 2'd0, 1'b0, {tag, "_lenhdr"});
    if (n == 4'd0) begin
      cyc(1'b1, 6'b100000, 2'd0, 1'b0, {tag, "_err"});
    end else begin
      for (int i = 0; i < int'(n) && i < lim; i++)
        cyc(pay[i], {1'b0, 1'b1, (pay[i] ? onehot : 4'b0000)}, p, 1'b1, {tag, "_data"});
    end
  endtask

  initial begin
    rst   = 1'b1;
    serIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("reset_outs", {2'b00, error, validOut, out}, 8'h00);
      check("reset_port", {6'b0, activePort}, 8'h00);
    end
    rst = 1'b0;
    cyc(1'b1, 6'b000000, 2'd0, 1'b1, "idle0");
    cyc(1'b1, 6'b000000, 2'd0, 1'b1, "idle1");

    // Port 3, N=12, payload containing zeros
    frame(2'd3, 4'd12, 15'h0B2D, 15, "p3n12");
    cyc(1'b1, 6'b000000, 2'd0, 1'b0, "after12_a");
    cyc(1'b0, 6'b000000, 2'd0, 1'b0, "after12_b_start");
    // That 0 was a start bit: finish the header of a port 1, N=1 frame.
    for (int i = 0; i < 2; i++) cyc(i == 1, 6'b000000, 2'd0, 1'b0, "p1a_porthdr");
    for (int i = 0; i < 4; i++) cyc(i == 3, 6'b000000, 2'd0, 1'b0, "p1a_lenhdr");
    cyc(1'b1, 6'b010010, 2'd1, 1'b1, "p1a_data1");

    frame(2'd1, 4'd1, 15'h0001, 15, "p1one");
    frame(2'd1, 4'd1, 15'h0000, 15, "p1zero");
    cyc(1'b1, 6'b000000, 2'd0, 1'b0, "idle2");

    // Zero-length frame, then an immediate start bit
    frame(2'd2, 4'd0, 15'h0000, 15, "err");
    frame(2'd2, 4'd2, 15'h0003, 15, "aftererr");

    // Back-to-back frames with zero payload bits
    frame(2'd0, 4'd2, 15'h0000, 15, "b2b_a");
    frame(2'd3, 4'd3, 15'h0002, 15, "b2b_b");
    cyc(1'b1, 6'b000000, 2'd0, 1'b0, "b2b_idle");

    // Reset in the middle of a payload
    frame(2'd3, 4'd12, 15'h0FFF, 5, "midrst");
    serIn = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("midrst_outs", {2'b00, error, validOut, out}, 8'h00);
    check("midrst_port", {6'b0, activePort}, 8'h00);
    @(posedge clk);
    #1;
    check("midrst_hold", {2'b00, error, validOut, out}, 8'h00);
    rst = 1'b0;
    cyc(1'b1, 6'b000000, 2'd0, 1'b1, "postrst_idle");
    frame(2'd2, 4'd3, 15'h0005, 15, "postrst");
    cyc(1'b1, 6'b000000, 2'd0, 1'b0, "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
